// File: rtl/mtr_drv_pwm.sv
// mtr_drv_pwm: two-side complementary PWM with dead time, over-current blanking and sticky shutdown.
module mtr_drv_pwm #(
   parameter int NONOVERLAP = 32,
   parameter int OVR_BLANK  = 128,
   parameter int OVR_LIMIT  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] lft_spd,
   input  logic [11:0] rght_spd,
   input  logic        OVR_I,
   output logic        lft_PWM1,
   output logic        lft_PWM2,
   output logic        rght_PWM1,
   output logic        rght_PWM2,
   output logic        PWM_synch,
   output logic        OVR_I_shtdwn
);
   logic [10:0]      cnt_q, cnt_d;
   logic [1:0][10:0] duty_q, duty_d;
   logic [1:0][5:0]  dead_q, dead_d;
   logic [1:0][11:0] spd;
   logic [1:0]       sig_q, sig_d, p1_q, p1_d, p2_q, p2_d, ovr_q;
   logic [7:0]       blank_q, blank_d;
   logic [3:0]       evt_q, evt_d;
   logic             flag_q, flag_d, synch_q, synch_d, shtdwn_q, shtdwn_d;
   logic             end_p, valid;

   assign spd   = {rght_spd, lft_spd};
   assign end_p = cnt_q == 11'h7FF;
   assign valid = ovr_q[1] && blank_q == 8'd0 && |{p1_q, p2_q};

   always_comb begin
      cnt_d   = cnt_q + 11'd1;
      synch_d = cnt_q == 11'd0;
      for (int i = 0; i < 2; i++) begin
         duty_d[i] = end_p ? 11'((spd[i] ^ 12'h800) >> 1) : duty_q[i];
         sig_d[i]  = cnt_q < duty_q[i];
         // a raw edge blanks both legs; the legs follow PWM_sig once the dead count is spent
         dead_d[i] = (sig_d[i] != sig_q[i]) ? 6'(NONOVERLAP) :
                     (dead_q[i] != 6'd0) ? dead_q[i] - 6'd1 : 6'd0;
         p2_d[i]   = sig_d[i] == sig_q[i] && dead_q[i] <= 6'd1 && !shtdwn_q && sig_q[i];
         p1_d[i]   = sig_d[i] == sig_q[i] && dead_q[i] <= 6'd1 && !shtdwn_q && !sig_q[i];
      end
      blank_d  = |({p1_d, p2_d} & ~{p1_q, p2_q}) ? 8'(OVR_BLANK) :
                 (blank_q != 8'd0) ? blank_q - 8'd1 : 8'd0;
      flag_d   = synch_d ? 1'b0 : flag_q | valid;
      evt_d    = !end_p ? evt_q : !flag_q ? 4'd0 :
                 (evt_q == 4'(OVR_LIMIT)) ? evt_q : evt_q + 4'd1;
      shtdwn_d = shtdwn_q || evt_d == 4'(OVR_LIMIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= 11'd0;
         duty_q   <= {11'h400, 11'h400};
         dead_q   <= '0;
         sig_q    <= '0;
         p1_q     <= '0;
         p2_q     <= '0;
         ovr_q    <= '0;
         blank_q  <= 8'd0;
         evt_q    <= 4'd0;
         flag_q   <= 1'b0;
         synch_q  <= 1'b0;
         shtdwn_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         duty_q   <= duty_d;
         dead_q   <= dead_d;
         sig_q    <= sig_d;
         p1_q     <= p1_d;
         p2_q     <= p2_d;
         ovr_q    <= {ovr_q[0], OVR_I};
         blank_q  <= blank_d;
         evt_q    <= evt_d;
         flag_q   <= flag_d;
         synch_q  <= synch_d;
         shtdwn_q <= shtdwn_d;
      end
   end

   assign lft_PWM1     = p1_q[0];
   assign lft_PWM2     = p2_q[0];
   assign rght_PWM1    = p1_q[1];
   assign rght_PWM2    = p2_q[1];
   assign PWM_synch    = synch_q;
   assign OVR_I_shtdwn = shtdwn_q;
endmodule

// File: tb/tb_mtr_drv_pwm.sv
// tb_mtr_drv_pwm: directed bench for mtr_drv_pwm with a FIFO of expected per-period measurements.
module tb_mtr_drv_pwm;
   logic        clk = 1'b0, rst_n = 1'b0, OVR_I = 1'b0;
   logic [11:0] lft_spd = 12'h000, rght_spd = 12'h000;
   logic        lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, OVR_I_shtdwn;
   logic [5:0]  outs;
   int          exp_q[$];
   int          n_cmp = 0, n_err = 0;
   int          l1, l2, r1, r2, nsy, ovl, dmin, dmax, run;
   logic        sy_end;

   always #5 clk = ~clk;

   mtr_drv_pwm dut (
      .clk(clk), .rst_n(rst_n), .lft_spd(lft_spd), .rght_spd(rght_spd), .OVR_I(OVR_I),
      .lft_PWM1(lft_PWM1), .lft_PWM2(lft_PWM2), .rght_PWM1(rght_PWM1), .rght_PWM2(rght_PWM2),
      .PWM_synch(PWM_synch), .OVR_I_shtdwn(OVR_I_shtdwn)
   );

   assign outs = {lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, OVR_I_shtdwn};

   task automatic cmp(input string tag, input int obs, input int e);
      n_cmp++;
      assert (obs === e) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
      end
   endtask

   task automatic push(input int v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input int obs);
      cmp(tag, obs, (exp_q.size() != 0) ? exp_q.pop_front() : -1);
   endtask

   task automatic wait_synch();
      int k = 0;
      while (!PWM_synch && k < 4096) begin
         @(negedge clk);
         k++;
      end
      cmp("synch_seen", int'(PWM_synch), 1);
   endtask

   // One full period from a PWM_synch sample; optional speed change at ci and OVR_I pulse at oa.
   task automatic measure(input int ci, input logic [11:0] cl, input logic [11:0] cr,
                          input int oa, input int olen);
      wait_synch();
      l1 = 0; l2 = 0; r1 = 0; r2 = 0; nsy = 0; ovl = 0; run = 0; dmin = 9999; dmax = 0;
      for (int i = 0; i < 2048; i++) begin
         if (i == ci) begin
            lft_spd  = cl;
            rght_spd = cr;
         end
         OVR_I = (i >= oa && i < oa + olen);
         l1 += int'(lft_PWM1);
         l2 += int'(lft_PWM2);
         r1 += int'(rght_PWM1);
         r2 += int'(rght_PWM2);
         nsy += int'(PWM_synch);
         ovl += int'((lft_PWM1 && lft_PWM2) || (rght_PWM1 && rght_PWM2));
         if (!lft_PWM1 && !lft_PWM2) run++;
         else if (run > 0) begin
            dmin = (run < dmin) ? run : dmin;
            dmax = (run > dmax) ? run : dmax;
            run  = 0;
         end
         @(negedge clk);
      end
      OVR_I  = 1'b0;
      sy_end = PWM_synch;
   endtask

   task automatic std_push();
      push(0); push(1); push(1);
   endtask

   task automatic std_chk();
      chk("overlap", ovl);
      chk("synch_cnt", nsy);
      chk("synch_next", int'(sy_end));
   endtask

   initial begin
      // reset state
      push(0);
      repeat (3) @(negedge clk);
      chk("reset_outs", int'(outs));
      // release; first strobe one clock later
      push(0); push(1);
      rst_n = 1'b1;
      chk("synch_at_release", int'(PWM_synch));
      @(negedge clk);
      chk("synch_first", int'(PWM_synch));
      // spd 0 both sides
      push(992); push(992); push(992); push(992); push(32); push(32); std_push();
      measure(-1, 12'h000, 12'h000, -1, 0);
      chk("a_l2", l2); chk("a_l1", l1); chk("a_r2", r2); chk("a_r1", r1);
      chk("a_dead_min", dmin); chk("a_dead_max", dmax); std_chk();
      // full-scale commands, effective one period later
      push(992); std_push();
      measure(5, 12'h7FF, 12'h800, -1, 0);
      chk("b0_l2", l2); std_chk();
      push(0); push(33); push(2048); push(0); std_push();
      measure(-1, 12'h7FF, 12'h800, -1, 0);
      chk("b1_l1", l1); chk("b1_l2low", 2048 - l2); chk("b1_r1", r1); chk("b1_r2", r2); std_chk();
      push(0); push(33); std_push();
      measure(-1, 12'h7FF, 12'h800, -1, 0);
      chk("b2_l1", l1); chk("b2_l2low", 2048 - l2); std_chk();
      // mid-period change at cnt 0x200
      std_push();
      measure(5, 12'h000, 12'h000, -1, 0);
      std_chk();
      push(992); push(992); std_push();
      measure(12'h1FF, 12'h400, 12'h000, -1, 0);
      chk("c0_l2", l2); chk("c0_r2", r2); std_chk();
      push(1504); push(480); std_push();
      measure(-1, 12'h400, 12'h000, -1, 0);
      chk("c1_l2", l2); chk("c1_l1", l1); std_chk();
      // over-current inside blanking window never counts
      push(0);
      measure(5, 12'h000, 12'h000, 40, 20);
      chk("d_shtdwn0", int'(OVR_I_shtdwn));
      for (int p = 0; p < 4; p++) begin
         push(0); push(992);
         measure(-1, 12'h000, 12'h000, 40, 20);
         chk("d_shtdwn", int'(OVR_I_shtdwn)); chk("d_l2", l2);
      end
      // three event periods then a clean one: no shutdown
      for (int p = 0; p < 3; p++) begin
         push(0);
         measure(-1, 12'h000, 12'h000, 300, 20);
         chk("e3_shtdwn", int'(OVR_I_shtdwn));
      end
      push(0);
      measure(-1, 12'h000, 12'h000, -1, 0);
      chk("e_clean_shtdwn", int'(OVR_I_shtdwn));
      // four event periods: shutdown after the fourth period end
      for (int p = 0; p < 4; p++) begin
         push((p == 3) ? 1 : 0);
         measure(-1, 12'h000, 12'h000, 300, 20);
         chk("e4_shtdwn", int'(OVR_I_shtdwn));
      end
      push(0); push(0); push(0); push(0); push(1); std_push();
      measure(-1, 12'h000, 12'h000, -1, 0);
      chk("s_l1", l1); chk("s_l2", l2); chk("s_r1", r1); chk("s_r2", r2);
      chk("s_shtdwn", int'(OVR_I_shtdwn)); std_chk();
      // asynchronous reset mid-period while shut down
      lft_spd  = 12'h800;
      rght_spd = 12'h7FF;
      repeat (100) @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      push(0);
      #1 chk("async_reset_outs", int'(outs));
      repeat (2) @(negedge clk);
      push(0); push(1);
      rst_n = 1'b1;
      chk("f_synch_at_release", int'(PWM_synch));
      @(negedge clk);
      chk("f_synch_first", int'(PWM_synch));
      push(992); push(992); push(0); std_push();
      measure(-1, 12'h800, 12'h7FF, -1, 0);
      chk("f0_l2", l2); chk("f0_r2", r2); chk("f0_shtdwn", int'(OVR_I_shtdwn)); std_chk();
      push(2048); push(0); push(0); push(2015); std_push();
      measure(-1, 12'h800, 12'h7FF, -1, 0);
      chk("f1_l1", l1); chk("f1_l2", l2); chk("f1_r1", r1); chk("f1_r2", r2); std_chk();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mtr_drv_pwm.md
Name: mtr_drv_pwm

Overview:
- Motor-drive back end that consumes the signed 12-bit left/right speed commands from the balance/steer math.
- Converts each command into a complementary, non-overlapping PWM pair for one H-bridge side; there are two sides, left and right.
- Provides an over-current blanking window and a sticky shutdown, plus a period-synch strobe for downstream sampling logic.

Parameters:
- NONOVERLAP, 32: dead-time in clocks; both legs of a pair are low after any PWM edge. Range 1..63.
- OVR_BLANK, 128: clocks after any leg turn-on during which OVR_I is ignored. Range 1..255.
- OVR_LIMIT, 4: number of consecutive PWM periods with an over-current event that causes shutdown. Range 1..15.

Ports:
- clk  in  1: system clock.
- rst_n  in  1: asynchronous active-low reset.
- lft_spd  in  12: signed left speed command, -2048..2047.
- rght_spd  in  12: signed right speed command, -2048..2047.
- OVR_I  in  1: asynchronous over-current comparator output, active high.
- lft_PWM1  out  1: left low-side leg, complement phase.
- lft_PWM2  out  1: left high-side leg, true phase.
- rght_PWM1  out  1: right low-side leg, complement phase.
- rght_PWM2  out  1: right high-side leg, true phase.
- PWM_synch  out  1: one-clock strobe at the start of each PWM period.
- OVR_I_shtdwn  out  1: sticky over-current shutdown flag.

Behaviour:
- Reset (rst_n low, asynchronous): all registers clear.
  - All four PWM outputs = 0; PWM_synch = 0; OVR_I_shtdwn = 0.
  - cnt = 0; both latched duties = 11'h400; event counter = 0.
- Period counter: cnt is 11 bits, free-running, +1 per clk, wraps 11'h7FF -> 0. Period = 2048 clks.
- PWM_synch: registered, high for exactly the one cycle in which cnt == 0.
- Duty mapping: duty = {~spd[11], spd[10:1]}, 11 bits unsigned.
  - Equivalent to (spd + 2048) >> 1.
  - spd 0 -> 11'h400; spd 12'h7FF -> 11'h7FF; spd 12'h800 -> 11'h000.
- Duty buffering: each side's duty register loads only on the cycle where cnt == 11'h7FF.
  - A new command therefore takes effect from the following period.
  - Mid-period changes to lft_spd/rght_spd have no effect on the current period.
- Raw PWM: PWM_sig <= (cnt < duty_latched) every clk, per side. This gives 1 clk latency from cnt.
- Non-overlap, per side:
  - On any change of PWM_sig, both legs go low and the dead counter loads NONOVERLAP.
  - The dead counter decrements each clk. When it reaches 0: PWM2 <= PWM_sig and PWM1 <= ~PWM_sig.
  - A further PWM_sig change while counting reloads the counter, restarting the dead time.
  - Outputs are registered. PWM1 and PWM2 are never high in the same cycle.
- Over-current handling:
  - OVR_I passes through a 2-flop synchronizer.
  - A blank counter (8-bit) reloads OVR_BLANK on any rising edge of any of the four legs and decrements to 0.
  - The synchronized OVR_I is valid only when the blank counter = 0 and at least one leg is high.
  - At most one event is recorded per period (per-period flag, cleared at cnt == 0).
  - At end of period (cnt == 11'h7FF): if the flag is set, event counter +1, otherwise event counter = 0.
  - When the event counter reaches OVR_LIMIT:
    - OVR_I_shtdwn = 1, sticky until rst_n.
    - All four legs forced to 0 from the next clk. cnt and PWM_synch keep running.
- Boundaries:
  - duty 0: PWM_sig stays 0, so PWM1 is steady high and PWM2 steady low after the initial dead time.
  - duty 11'h7FF: PWM_sig is low for 1 clk per period. Result per period: PWM2 low for NONOVERLAP+1 consecutive clks, PWM1 never high.
  - Reset mid-period: outputs drop to 0 immediately (asynchronously); the first PWM_synch comes 1 clk after release.

Test Plan:
- Reset release, spd=0 both sides:
  - PWM_synch every 2048 clks.
  - PWM_sig high 1024 clks per period.
  - PWM2 and PWM1 each high 992 clks per period.
  - Every transition of a pair separated by exactly 32 clks with both legs low.
- lft_spd=12'h7FF, rght_spd=12'h800:
  - Left: PWM1 never high; PWM2 low 33 consecutive clks per period.
  - Right: PWM1 constantly high, PWM2 constantly low.
- Change lft_spd from 0 to 12'h400 at cnt=11'h200:
  - Current period keeps 1024-clk PWM_sig.
  - The next period shows PWM_sig high 1536 clks (duty 11'h600).
- Assert OVR_I for 20 clks within the first 128 clks after each PWM2 rise, every period:
  - OVR_I_shtdwn stays 0 and the event counter stays 0.
- Assert OVR_I past blanking in 4 consecutive periods:
  - OVR_I_shtdwn rises after the 4th period end; all legs held 0 while PWM_synch continues.
  - With only 3 event periods followed by 1 clean period, no shutdown occurs.
- Assert rst_n low mid-period while in shutdown:
  - All outputs 0 immediately, OVR_I_shtdwn cleared.
  - After release, PWM restarts with duty 11'h400 until the first cnt == 11'h7FF load.
